// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers decoded fields, resolves forwarding from
// EX/MEM and MEM/WB, extends the immediate and presents ALU operands.
// Also detects load-use hazards and counts stall cycles.
module ex_operand_stage #(
   parameter int DATA_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [5:0]                 in_opcode,
   input  logic [5:0]                 in_funct,
   input  logic [REG_ADDR_WIDTH-1:0]  in_rs_num,
   input  logic [REG_ADDR_WIDTH-1:0]  in_rt_num,
   input  logic [DATA_WIDTH-1:0]      in_rs_val,
   input  logic [DATA_WIDTH-1:0]      in_rt_val,
   input  logic [15:0]                in_imm,
   input  logic [REG_ADDR_WIDTH-1:0]  in_dest_num,
   input  logic                       in_reg_write,
   input  logic                       in_mem_read,
   input  logic                       flush,
   input  logic                       exmem_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0]  exmem_dest_num,
   input  logic [DATA_WIDTH-1:0]      exmem_result,
   input  logic                       memwb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0]  memwb_dest_num,
   input  logic [DATA_WIDTH-1:0]      memwb_result,
   output logic                       stall,
   output logic [DATA_WIDTH-1:0]      alu_operand_a,
   output logic [DATA_WIDTH-1:0]      alu_operand_b,
   output logic [5:0]                 alu_opcode,
   output logic [5:0]                 alu_funct,
   output logic                       ex_valid,
   output logic [REG_ADDR_WIDTH-1:0]  ex_dest_num,
   output logic                       ex_reg_write,
   output logic                       ex_mem_read,
   output logic [DATA_WIDTH-1:0]      ex_store_data,
   output logic [STALL_CNT_WIDTH-1:0] stall_count
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;

   localparam logic [REG_ADDR_WIDTH-1:0]  REG_ZERO = {REG_ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0]      DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};
   localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

   // Pipeline register contents
   logic                       exValid_r;
   logic [5:0]                 exOpcode_r;
   logic [5:0]                 exFunct_r;
   logic [REG_ADDR_WIDTH-1:0]  exRsNum_r;
   logic [REG_ADDR_WIDTH-1:0]  exRtNum_r;
   logic [DATA_WIDTH-1:0]      exRsVal_r;
   logic [DATA_WIDTH-1:0]      exRtVal_r;
   logic [15:0]                exImm_r;
   logic [REG_ADDR_WIDTH-1:0]  exDestNum_r;
   logic                       exRegWrite_r;
   logic                       exMemRead_r;
   logic [STALL_CNT_WIDTH-1:0] stallCount_r;

   logic                       stall_s;
   logic                       loadBubble_s;
   logic [DATA_WIDTH-1:0]      fwdRs_s;
   logic [DATA_WIDTH-1:0]      fwdRt_s;
   logic [DATA_WIDTH-1:0]      operandB_s;

   // Forwarding mux for one source register; $0 is never forwarded and
   // EX/MEM wins over MEM/WB because it holds the younger result.
   function automatic logic [DATA_WIDTH-1:0] fwdSelect(
      input logic [REG_ADDR_WIDTH-1:0] num,
      input logic [DATA_WIDTH-1:0]     regVal,
      input logic                      exWr,
      input logic [REG_ADDR_WIDTH-1:0] exDest,
      input logic [DATA_WIDTH-1:0]     exVal,
      input logic                      wbWr,
      input logic [REG_ADDR_WIDTH-1:0] wbDest,
      input logic [DATA_WIDTH-1:0]     wbVal
   );
      logic [DATA_WIDTH-1:0] sel;
      if (num == REG_ZERO) begin
         sel = regVal;
      end else if (exWr && (exDest == num)) begin
         sel = exVal;
      end else if (wbWr && (wbDest == num)) begin
         sel = wbVal;
      end else begin
         sel = regVal;
      end
      return sel;
   endfunction

   // Load-use hazard: the load in EX cannot feed the decode instruction in
   // time, so hold decode. rt is compared even when unused (conservative).
   always_comb begin
      stall_s      = 1'b0;
      loadBubble_s = 1'b0;
      if (exValid_r && exMemRead_r && (exDestNum_r != REG_ZERO) && in_valid &&
          ((exDestNum_r == in_rs_num) || (exDestNum_r == in_rt_num))) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end
      loadBubble_s = flush | stall_s | ~in_valid;
   end

   // ID/EX register: bubble on reset, flush, stall or empty decode.
   always_ff @(posedge clk) begin
      if (reset || loadBubble_s) begin
         exValid_r    <= 1'b0;
         exOpcode_r   <= OP_RTYPE;
         exFunct_r    <= FN_ADD;
         exRsNum_r    <= REG_ZERO;
         exRtNum_r    <= REG_ZERO;
         exRsVal_r    <= DATA_ZERO;
         exRtVal_r    <= DATA_ZERO;
         exImm_r      <= 16'h0000;
         exDestNum_r  <= REG_ZERO;
         exRegWrite_r <= 1'b0;
         exMemRead_r  <= 1'b0;
      end else begin
         exValid_r    <= 1'b1;
         exOpcode_r   <= in_opcode;
         exFunct_r    <= in_funct;
         exRsNum_r    <= in_rs_num;
         exRtNum_r    <= in_rt_num;
         exRsVal_r    <= in_rs_val;
         exRtVal_r    <= in_rt_val;
         exImm_r      <= in_imm;
         exDestNum_r  <= in_dest_num;
         exRegWrite_r <= in_reg_write;
         exMemRead_r  <= in_mem_read;
      end
   end

   // Saturating count of cycles spent stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCount_r <= {STALL_CNT_WIDTH{1'b0}};
      end else if (stall_s && (stallCount_r != CNT_MAX)) begin
         stallCount_r <= stallCount_r + CNT_ONE;
      end else begin
         stallCount_r <= stallCount_r;
      end
   end

   // Forwarded source values and operand-B selection by registered opcode.
   always_comb begin
      fwdRs_s = fwdSelect(exRsNum_r, exRsVal_r, exmem_reg_write, exmem_dest_num,
                          exmem_result, memwb_reg_write, memwb_dest_num, memwb_result);
      fwdRt_s = fwdSelect(exRtNum_r, exRtVal_r, exmem_reg_write, exmem_dest_num,
                          exmem_result, memwb_reg_write, memwb_dest_num, memwb_result);
      operandB_s = fwdRt_s;
      case (exOpcode_r)
         OP_ADDI, OP_LW, OP_SW: operandB_s = {{(DATA_WIDTH-16){exImm_r[15]}}, exImm_r};
         OP_XORI:               operandB_s = {{(DATA_WIDTH-16){1'b0}}, exImm_r};
         OP_RTYPE, OP_BEQ, OP_BNE: operandB_s = fwdRt_s;
         OP_J, OP_JAL:          operandB_s = DATA_ZERO;
         default:               operandB_s = fwdRt_s;
      endcase
   end

   assign stall         = stall_s;
   assign alu_operand_a = fwdRs_s;
   assign alu_operand_b = operandB_s;
   assign alu_opcode    = exOpcode_r;
   assign alu_funct     = exFunct_r;
   assign ex_valid      = exValid_r;
   assign ex_dest_num   = exDestNum_r;
   assign ex_reg_write  = exRegWrite_r;
   assign ex_mem_read   = exMemRead_r;
   assign ex_store_data = fwdRt_s;
   assign stall_count   = stallCount_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: expected EX contents are queued when
// decode is driven and popped one cycle later when the stage presents them.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [5:0]  in_opcode, in_funct;
   logic [4:0]  in_rs_num, in_rt_num, in_dest_num;
   logic [31:0] in_rs_val, in_rt_val;
   logic [15:0] in_imm;
   logic        in_reg_write, in_mem_read, flush;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_dest_num, memwb_dest_num;
   logic [31:0] exmem_result, memwb_result;
   logic        stall;
   logic [31:0] alu_operand_a, alu_operand_b, ex_store_data;
   logic [5:0]  alu_opcode, alu_funct;
   logic        ex_valid, ex_reg_write, ex_mem_read;
   logic [4:0]  ex_dest_num;
   logic [15:0] stall_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] a, b, store;
      logic [5:0]  opc, fn;
      logic        valid, rw, mr;
      logic [4:0]  dest;
   } exp_t;

   exp_t  expQ[$];
   string tagQ[$];

   ex_operand_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_funct(in_funct), .in_rs_num(in_rs_num), .in_rt_num(in_rt_num),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_dest_num(in_dest_num), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read), .flush(flush),
      .exmem_reg_write(exmem_reg_write), .exmem_dest_num(exmem_dest_num),
      .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
      .memwb_dest_num(memwb_dest_num), .memwb_result(memwb_result),
      .stall(stall), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_opcode(alu_opcode), .alu_funct(alu_funct), .ex_valid(ex_valid),
      .ex_dest_num(ex_dest_num), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [15:0] imm, input logic [4:0] dest,
                        input logic rw, input logic mr);
      in_valid = v; in_opcode = opc; in_funct = fn; in_rs_num = rs; in_rt_num = rt;
      in_rs_val = rsv; in_rt_val = rtv; in_imm = imm; in_dest_num = dest;
      in_reg_write = rw; in_mem_read = mr;
   endtask

   task automatic setFwd(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                         input logic mw, input logic [4:0] md, input logic [31:0] mres);
      exmem_reg_write = ew; exmem_dest_num = ed; exmem_result = er;
      memwb_reg_write = mw; memwb_dest_num = md; memwb_result = mres;
   endtask

   task automatic expectOut(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] store, input logic [5:0] opc,
                            input logic [5:0] fn, input logic v, input logic rw,
                            input logic mr, input logic [4:0] dest);
      exp_t e;
      e.a = a; e.b = b; e.store = store; e.opc = opc; e.fn = fn;
      e.valid = v; e.rw = rw; e.mr = mr; e.dest = dest;
      expQ.push_back(e);
      tagQ.push_back(tag);
   endtask

   task automatic expectBubble(input string tag);
      expectOut(tag, 32'h0, 32'h0, 32'h0, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Check stall before the edge, clock once, then compare the queued entry.
   task automatic step(input logic expStall);
      exp_t  e;
      string t;
      #1;
      chk("stall", 32'(stall), 32'(expStall));
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = expQ.pop_front();
         t = tagQ.pop_front();
         chk({t, ".opA"}, alu_operand_a, e.a);
         chk({t, ".opB"}, alu_operand_b, e.b);
         chk({t, ".store"}, ex_store_data, e.store);
         chk({t, ".opcode"}, 32'(alu_opcode), 32'(e.opc));
         chk({t, ".funct"}, 32'(alu_funct), 32'(e.fn));
         chk({t, ".valid"}, 32'(ex_valid), 32'(e.valid));
         chk({t, ".regWrite"}, 32'(ex_reg_write), 32'(e.rw));
         chk({t, ".memRead"}, 32'(ex_mem_read), 32'(e.mr));
         chk({t, ".dest"}, 32'(ex_dest_num), 32'(e.dest));
      end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      // Reset held two cycles with a real instruction on decode
      drive(1'b1, 6'h08, 6'h00, 5'd8, 5'd0, 32'd5, 32'd0, 16'h1234, 5'd9, 1'b1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset.opcode", 32'(alu_opcode), 32'h00);
      chk("reset.funct", 32'(alu_funct), 32'h20);
      chk("reset.opA", alu_operand_a, 32'h0);
      chk("reset.opB", alu_operand_b, 32'h0);
      chk("reset.store", ex_store_data, 32'h0);
      chk("reset.valid", 32'(ex_valid), 32'd0);
      chk("reset.stallCount", 32'(stall_count), 32'd0);
      chk("reset.stall", 32'(stall), 32'd0);
      reset = 1'b0;

      // ADDI sign-extends the immediate
      drive(1'b1, 6'h08, 6'h00, 5'd8, 5'd0, 32'd5, 32'd0, 16'hFFFE, 5'd9, 1'b1, 1'b0);
      expectOut("addi", 32'd5, 32'hFFFF_FFFE, 32'h0, 6'h08, 6'h00, 1'b1, 1'b1, 1'b0, 5'd9);
      step(1'b0);

      // XORI zero-extends the immediate
      drive(1'b1, 6'h0E, 6'h00, 5'd8, 5'd0, 32'd5, 32'd0, 16'hFFFE, 5'd9, 1'b1, 1'b0);
      expectOut("xori", 32'd5, 32'h0000_FFFE, 32'h0, 6'h0E, 6'h00, 1'b1, 1'b1, 1'b0, 5'd9);
      step(1'b0);

      // Forwarding priority on rs=$9: EX/MEM beats MEM/WB
      drive(1'b1, 6'h00, 6'h20, 5'd9, 5'd0, 32'd1, 32'd0, 16'h0, 5'd3, 1'b1, 1'b0);
      setFwd(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
      expectOut("fwd_exmem", 32'hAA, 32'h0, 32'h0, 6'h00, 6'h20, 1'b1, 1'b1, 1'b0, 5'd3);
      step(1'b0);

      setFwd(1'b0, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
      expectOut("fwd_memwb", 32'hBB, 32'h0, 32'h0, 6'h00, 6'h20, 1'b1, 1'b1, 1'b0, 5'd3);
      step(1'b0);

      // $0 is never forwarded
      drive(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 32'd0, 32'd0, 16'h0, 5'd3, 1'b1, 1'b0);
      setFwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
      expectOut("fwd_zero", 32'h0, 32'h0, 32'h0, 6'h00, 6'h20, 1'b1, 1'b1, 1'b0, 5'd3);
      step(1'b0);

      // Load-use: LW $10 then ADD using $10
      setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd10, 32'd0, 32'h55, 16'h0004, 5'd10, 1'b1, 1'b1);
      expectOut("lw", 32'h0, 32'h4, 32'h55, 6'h23, 6'h00, 1'b1, 1'b1, 1'b1, 5'd10);
      step(1'b0);

      drive(1'b1, 6'h00, 6'h20, 5'd10, 5'd2, 32'h10, 32'h20, 16'h0, 5'd4, 1'b1, 1'b0);
      expectBubble("loaduse_bubble");
      step(1'b1);
      chk("loaduse.stallCount", 32'(stall_count), 32'd1);

      // Held instruction now captured; loaded value arrives via EX/MEM
      setFwd(1'b1, 5'd10, 32'h99, 1'b0, 5'd0, 32'h0);
      expectOut("loaduse_capture", 32'h99, 32'h20, 32'h20, 6'h00, 6'h20, 1'b1, 1'b1, 1'b0, 5'd4);
      step(1'b0);
      chk("capture.stallCount", 32'(stall_count), 32'd1);

      // Flush during a stall still kills the decode instruction
      setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd10, 32'd0, 32'h0, 16'h0008, 5'd10, 1'b1, 1'b1);
      expectOut("lw2", 32'h0, 32'h8, 32'h0, 6'h23, 6'h00, 1'b1, 1'b1, 1'b1, 5'd10);
      step(1'b0);

      drive(1'b1, 6'h00, 6'h20, 5'd3, 5'd10, 32'h10, 32'h20, 16'h0, 5'd4, 1'b1, 1'b0);
      flush = 1'b1;
      expectBubble("flush_bubble");
      step(1'b1);
      chk("flush.stallCount", 32'(stall_count), 32'd2);

      flush = 1'b0;
      drive(1'b0, 6'h08, 6'h00, 5'd3, 5'd10, 32'h10, 32'h20, 16'h7, 5'd4, 1'b1, 1'b0);
      expectBubble("invalid_bubble");
      step(1'b0);
      chk("invalid.stallCount", 32'(stall_count), 32'd2);

      // SW: store data forwarded from MEM/WB, operand B sign-extended imm
      drive(1'b1, 6'h2B, 6'h00, 5'd0, 5'd11, 32'd0, 32'h0, 16'h8010, 5'd0, 1'b0, 1'b0);
      setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h1234);
      expectOut("sw", 32'h0, 32'hFFFF_8010, 32'h1234, 6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b0);

      // J: operand B forced to zero, store data still forwarded rt
      setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drive(1'b1, 6'h02, 6'h00, 5'd0, 5'd5, 32'd0, 32'h33, 16'h00FF, 5'd0, 1'b0, 1'b0);
      expectOut("j", 32'h0, 32'h0, 32'h33, 6'h02, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b0);

      // BEQ uses forwarded rt as operand B
      drive(1'b1, 6'h04, 6'h00, 5'd6, 5'd5, 32'h7, 32'h33, 16'h00FF, 5'd0, 1'b0, 1'b0);
      expectOut("beq", 32'h7, 32'h33, 32'h33, 6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b0);

      chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
